// File: rtl/checkpt_alloc.sv
// Branch checkpoint allocator: hands out checkpoints in program order from a
// circular window, reclaims resolved ones from the oldest end, and restores on mispredict.
module checkpt_alloc #(
  parameter int NCHECKPT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alloc_req,
  input  logic [5:0] alloc_rob,
  output logic       alloc_rdy,
  output logic [3:0] alloc_ndx,
  input  logic       resolve_v,
  input  logic [3:0] resolve_ndx,
  input  logic       resolve_mispred,
  output logic       restore_v,
  output logic [3:0] restore_ndx,
  output logic [5:0] restore_rob,
  output logic       free_v,
  output logic [3:0] free_ndx,
  output logic [4:0] count,
  output logic       err
);

  logic [NCHECKPT-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic [5:0]          rob_q [NCHECKPT];
  logic [3:0]          head_q, head_d, tail_q, tail_d;
  logic [4:0]          count_q, count_d;
  logic                err_q, err_d;
  logic                restore_v_q, free_v_q;
  logic [3:0]          restore_ndx_q, free_ndx_q;
  logic [5:0]          restore_rob_q;
  logic                alloc_fire, res_ok, res_bad, correct, mispred, reclaim;

  // Distance of an entry from the oldest live checkpoint, modulo the ring size.
  function automatic logic [3:0] age(input logic [3:0] ndx, input logic [3:0] base);
    return ndx - base;
  endfunction

  assign alloc_rdy  = (count_q != 5'(NCHECKPT)) & ~flush;
  assign alloc_fire = alloc_req & alloc_rdy;
  assign res_ok     = resolve_v & valid_q[resolve_ndx] & ~resolved_q[resolve_ndx];
  assign res_bad    = resolve_v & ~(valid_q[resolve_ndx] & ~resolved_q[resolve_ndx]);
  assign correct    = res_ok & ~resolve_mispred;
  assign mispred    = res_ok & resolve_mispred;
  assign reclaim    = valid_q[head_q] & resolved_q[head_q];

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    err_d      = err_q | res_bad;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      valid_d    = '0;
      resolved_d = '0;
    end else begin
      if (reclaim) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 4'd1;
      end
      if (correct) resolved_d[resolve_ndx] = 1'b1;
      if (mispred) begin
        // The mispredicted entry and everything younger leave the window;
        // a same-cycle allocation is the youngest of all, so it is dropped too.
        for (int i = 0; i < NCHECKPT; i++) begin
          if (valid_q[i] && (age(4'(i), head_q) >= age(resolve_ndx, head_q)))
            valid_d[i] = 1'b0;
        end
        tail_d  = resolve_ndx;
        count_d = {1'b0, age(resolve_ndx, head_d)};
      end else if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + 4'd1;
        count_d            = count_q + 5'd1 - {4'd0, reclaim};
      end else begin
        count_d = count_q - {4'd0, reclaim};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      resolved_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      restore_v_q   <= 1'b0;
      restore_ndx_q <= '0;
      restore_rob_q <= '0;
      free_v_q      <= 1'b0;
      free_ndx_q    <= '0;
      for (int i = 0; i < NCHECKPT; i++) rob_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      err_q      <= err_d;
      if (flush) begin
        restore_v_q   <= 1'b0;
        restore_ndx_q <= '0;
        restore_rob_q <= '0;
        free_v_q      <= 1'b0;
        free_ndx_q    <= '0;
      end else begin
        restore_v_q <= mispred;
        free_v_q    <= reclaim;
        if (mispred) begin
          restore_ndx_q <= resolve_ndx;
          restore_rob_q <= rob_q[resolve_ndx];
        end
        if (reclaim) free_ndx_q <= head_q;
        if (alloc_fire && !mispred) rob_q[tail_q] <= alloc_rob;
      end
    end
  end

  assign alloc_ndx   = tail_q;
  assign restore_v   = restore_v_q;
  assign restore_ndx = restore_ndx_q;
  assign restore_rob = restore_rob_q;
  assign free_v      = free_v_q;
  assign free_ndx    = free_ndx_q;
  assign count       = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_checkpt_alloc.sv
// Bench for checkpt_alloc: vector table for allocation/fill, hand sequences for
// reclaim timing, mispredict, errors, flush and async reset; pulses scoreboarded.
module tb_checkpt_alloc;
  logic       clk = 1'b0;
  logic       rst_n, flush, alloc_req, alloc_rdy, resolve_v, resolve_mispred;
  logic       restore_v, free_v, err;
  logic [5:0] alloc_rob, restore_rob;
  logic [3:0] alloc_ndx, resolve_ndx, restore_ndx, free_ndx;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_free[$];
  logic [9:0] exp_restore[$];

  typedef struct {
    logic       areq;
    logic [5:0] arob;
    logic       exp_rdy;
    logic [3:0] exp_ndx;
    logic [4:0] exp_cnt;
  } vec_t;
  vec_t tbl[$];

  checkpt_alloc #(.NCHECKPT(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_req(alloc_req),
    .alloc_rob(alloc_rob), .alloc_rdy(alloc_rdy), .alloc_ndx(alloc_ndx),
    .resolve_v(resolve_v), .resolve_ndx(resolve_ndx), .resolve_mispred(resolve_mispred),
    .restore_v(restore_v), .restore_ndx(restore_ndx), .restore_rob(restore_rob),
    .free_v(free_v), .free_ndx(free_ndx), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic areq, input logic [5:0] arob, input logic rdy,
                              input logic [3:0] ndx, input logic [4:0] cnt);
    vec_t v;
    v.areq = areq; v.arob = arob; v.exp_rdy = rdy; v.exp_ndx = ndx; v.exp_cnt = cnt;
    return v;
  endfunction

  // Pulse scoreboard: every free/restore pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (free_v) begin
        if (exp_free.size() == 0) chk("free_unexpected", 32'(free_v), 32'd0);
        else chk("free_ndx_sb", 32'(free_ndx), 32'(exp_free.pop_front()));
      end
      if (restore_v) begin
        if (exp_restore.size() == 0) chk("restore_unexpected", 32'(restore_v), 32'd0);
        else chk("restore_sb", 32'({restore_ndx, restore_rob}), 32'(exp_restore.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_req = 0; alloc_rob = 0;
    resolve_v = 0; resolve_ndx = 0; resolve_mispred = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    alloc_req = v.areq; alloc_rob = v.arob;
    #1;
    chk("alloc_rdy", 32'(alloc_rdy), 32'(v.exp_rdy));
    chk("alloc_ndx", 32'(alloc_ndx), 32'(v.exp_ndx));
    tick();
    alloc_req = 0;
    chk("count", 32'(count), 32'(v.exp_cnt));
    chk("err_clean", 32'(err), 32'd0);
  endtask

  task automatic alloc_n(input int n, input int rob_base);
    for (int i = 0; i < n; i++)
      apply_vec(mk(1'b1, 6'(rob_base + i), 1'b1, 4'(i), 5'(i + 1)));
  endtask

  initial begin
    // Allocate three, idle, fill to 16, then a refused request at full.
    tbl.push_back(mk(1'b1, 6'd5, 1'b1, 4'd0, 5'd1));
    tbl.push_back(mk(1'b1, 6'd6, 1'b1, 4'd1, 5'd2));
    tbl.push_back(mk(1'b1, 6'd7, 1'b1, 4'd2, 5'd3));
    tbl.push_back(mk(1'b0, 6'd0, 1'b1, 4'd3, 5'd3));
    for (int i = 3; i < 16; i++) tbl.push_back(mk(1'b1, 6'(i + 5), 1'b1, 4'(i), 5'(i + 1)));
    tbl.push_back(mk(1'b1, 6'd33, 1'b0, 4'd0, 5'd16));

    rst_n = 0;
    idle();
    tick();
    chk("rst_alloc_rdy", 32'(alloc_rdy), 32'd1);
    chk("rst_alloc_ndx", 32'(alloc_ndx), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_restore_v", 32'(restore_v), 32'd0);
    chk("rst_free_v", 32'(free_v), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1;
    #1;

    foreach (tbl[i]) apply_vec(tbl[i]);

    // Resolve head at full: free two cycles later, alloc_rdy returns with it.
    resolve_v = 1; resolve_ndx = 0;
    exp_free.push_back(4'd0);
    tick();
    idle();
    #1;
    chk("full_free_early", 32'(free_v), 32'd0);
    chk("full_rdy_still0", 32'(alloc_rdy), 32'd0);
    tick();
    chk("full_free_v", 32'(free_v), 32'd1);
    chk("full_free_ndx", 32'(free_ndx), 32'd0);
    chk("full_rdy_back", 32'(alloc_rdy), 32'd1);
    chk("full_wrap_ndx", 32'(alloc_ndx), 32'd0);
    chk("full_count15", 32'(count), 32'd15);
    alloc_req = 1; alloc_rob = 9;
    tick();
    idle();
    #1;
    chk("wrap_count16", 32'(count), 32'd16);
    chk("wrap_tail", 32'(alloc_ndx), 32'd1);

    // Out-of-order resolves wait for the head.
    do_reset();
    alloc_n(6, 10);
    resolve_v = 1; resolve_ndx = 3;
    tick();
    resolve_ndx = 1;
    tick();
    idle();
    tick();
    tick();
    chk("ooo_no_reclaim", 32'(count), 32'd6);
    resolve_v = 1; resolve_ndx = 0;
    exp_free.push_back(4'd0);
    exp_free.push_back(4'd1);
    tick();
    idle();
    #1;
    chk("ooo_free_early", 32'(free_v), 32'd0);
    tick();
    chk("ooo_free0_v", 32'(free_v), 32'd1);
    chk("ooo_free0_ndx", 32'(free_ndx), 32'd0);
    tick();
    chk("ooo_free1_v", 32'(free_v), 32'd1);
    chk("ooo_free1_ndx", 32'(free_ndx), 32'd1);
    tick();
    chk("ooo_free_stop", 32'(free_v), 32'd0);
    chk("ooo_count", 32'(count), 32'd4);

    // Mispredict 4 with a concurrent allocation request.
    do_reset();
    alloc_n(8, 20);
    alloc_req = 1; alloc_rob = 63;
    resolve_v = 1; resolve_ndx = 4; resolve_mispred = 1;
    exp_restore.push_back({4'd4, 6'd24});
    #1;
    chk("mp_alloc_ndx", 32'(alloc_ndx), 32'd8);
    tick();
    idle();
    #1;
    chk("mp_restore_v", 32'(restore_v), 32'd1);
    chk("mp_restore_ndx", 32'(restore_ndx), 32'd4);
    chk("mp_restore_rob", 32'(restore_rob), 32'd24);
    chk("mp_count", 32'(count), 32'd4);
    chk("mp_next_ndx", 32'(alloc_ndx), 32'd4);
    tick();
    chk("mp_pulse_end", 32'(restore_v), 32'd0);
    alloc_req = 1; alloc_rob = 1;
    tick();
    idle();
    chk("mp_realloc_cnt", 32'(count), 32'd5);

    // Bad resolve sets err; flush with a reclaim pending yields no pulse.
    do_reset();
    alloc_n(5, 30);
    resolve_v = 1; resolve_ndx = 9;
    tick();
    resolve_ndx = 0;
    tick();
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_change", 32'(count), 32'd5);
    idle();
    flush = 1; alloc_req = 1; alloc_rob = 2;
    #1;
    chk("flush_rdy", 32'(alloc_rdy), 32'd0);
    tick();
    idle();
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_tail", 32'(alloc_ndx), 32'd0);
    chk("flush_err_kept", 32'(err), 32'd1);
    chk("flush_free_v", 32'(free_v), 32'd0);
    chk("flush_restore_v", 32'(restore_v), 32'd0);
    tick();
    chk("flush_free_after", 32'(free_v), 32'd0);

    // Asynchronous reset while a restore pulse is live.
    do_reset();
    alloc_n(3, 40);
    resolve_v = 1; resolve_ndx = 1; resolve_mispred = 1;
    tick();
    idle();
    #1;
    chk("ar_restore_v", 32'(restore_v), 32'd1);
    chk("ar_restore_rob", 32'(restore_rob), 32'd41);
    rst_n = 0;
    #1;
    chk("ar_restore_v0", 32'(restore_v), 32'd0);
    chk("ar_restore_ndx0", 32'(restore_ndx), 32'd0);
    chk("ar_restore_rob0", 32'(restore_rob), 32'd0);
    chk("ar_count0", 32'(count), 32'd0);
    chk("ar_alloc_ndx0", 32'(alloc_ndx), 32'd0);
    chk("ar_alloc_rdy1", 32'(alloc_rdy), 32'd1);
    tick();
    rst_n = 1;
    tick();

    chk("sb_free_empty", 32'(exp_free.size()), 32'd0);
    chk("sb_restore_empty", 32'(exp_restore.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checkpt_alloc.md
Name: checkpt_alloc

Overview:
- Allocates and reclaims the 16 branch checkpoints (checkpt_ndx_t, 4 bits) of the out-of-order core.
- Checkpoints are handed out in program order from a circular window. A correctly predicted branch marks its checkpoint resolved; resolved checkpoints are reclaimed in order from the oldest end.
- A mispredict restores one checkpoint and discards it together with every younger checkpoint.
- Sits between rename/dispatch (allocation) and the branch unit (resolution), and drives the rename-map restore logic.

Parameters:
- NCHECKPT, 16: number of checkpoints; must equal 2**$bits(checkpt_ndx_t).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush  in  1  discard all checkpoints
- alloc_req  in  1  dispatch requests a checkpoint this cycle
- alloc_rob  in  6  ROB index (rob_ndx_t) of the allocating branch
- alloc_rdy  out  1  a checkpoint is available
- alloc_ndx  out  4  index granted when alloc_req & alloc_rdy
- resolve_v  in  1  branch resolution valid
- resolve_ndx  in  4  checkpoint being resolved
- resolve_mispred  in  1  resolution is a mispredict
- restore_v  out  1  one-cycle restore pulse
- restore_ndx  out  4  checkpoint to restore
- restore_rob  out  6  ROB index of the mispredicted branch
- free_v  out  1  one-cycle reclaim pulse
- free_ndx  out  4  reclaimed checkpoint
- count  out  5  live checkpoints, 0..16
- err  out  1  sticky protocol error

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: head=tail=0, count=0, all valid/resolved bits 0, alloc_rdy=1, alloc_ndx=0, restore_v=0, free_v=0, err=0. All index and ROB outputs reset to 0.
- Per-entry state: valid, resolved, rob[5:0]. head and tail are 4-bit pointers that wrap modulo 16.
- alloc_rdy = (count<16) & ~flush. It depends on registered state and flush only.
- alloc_ndx = tail, combinationally.
- Allocation fires on alloc_req & alloc_rdy. At the edge: valid[tail]=1, resolved[tail]=0, rob[tail]=alloc_rob, tail++.
- Correct resolve (resolve_v & ~resolve_mispred, entry valid and not resolved): resolved[k]=1 at the edge.
- Reclaim: at most one per cycle, decided on registered state. If valid[head] & resolved[head], then clear valid[head] and do head++. Next cycle free_v=1 and free_ndx=old head.
  - Resolve at edge t gives free_v at cycle t+2 when k is the head.
- Mispredict (resolve_v & resolve_mispred, entry k valid and not resolved):
  - Clear valid for k through tail-1, with wrap.
  - tail=k; count=(k-head_next) mod 16.
  - Next cycle: restore_v=1, restore_ndx=k, restore_rob=rob[k].
- Simultaneous events:
  - Allocate + reclaim: count unchanged.
  - Allocate + mispredict: the allocation is dropped, because the new entry is youngest. Dispatch must treat the grant as squashed because restore_v follows.
  - Mispredict + reclaim of a different head: both occur; count uses the advanced head.
  - flush beats everything: all state returns to reset values except err. No restore_v or free_v pulse is produced.
- Errors: resolving an invalid or already-resolved entry is ignored and sets err=1. err stays set until reset.
- Full: count=16 forces alloc_rdy=0. A reclaim in cycle c makes alloc_rdy=1 in cycle c+1.
- Empty: head==tail and count=0. No reclaim occurs.
- Wrap: pointers roll from 15 to 0 with no loss.
- Reset mid-operation: takes effect immediately; pending pulses are cancelled.

Test Plan:
- Reset, then allocate 3 (rob 5, 6, 7) -> alloc_ndx 0, 1, 2; count=3; free_v=0.
- Fill 16 -> alloc_rdy=0 at count=16. Resolve checkpoint 0 correct -> free_v with free_ndx=0 two cycles later; alloc_rdy=1 the cycle after reclaim; next alloc_ndx=0 (wrap).
- Allocate 0..5, resolve 3 then 1 correct -> no free_v, because head 0 is unresolved. Resolve 0 -> free_v pulses for 0 then 1 on consecutive cycles; head stops at 2.
- Allocate 0..7, mispredict checkpoint 4 in the same cycle as an alloc_req -> restore_v=1, restore_ndx=4, restore_rob=rob[4]; count=4; next alloc_ndx=4.
- Resolve an unallocated checkpoint 9 -> err=1, no state change. Then flush with 5 live -> count=0, head=tail=0, no pulses, err stays 1.
- Assert rst_n low mid-mispredict -> restore_v=0 and all outputs at reset values immediately, without waiting for a clock edge.
